// File: rtl/disp_source_arbiter.sv
// Round-robin arbiter sharing the 4-digit seven-segment display between N_SRC sources.
// Optional alert blink is built only when DISP_BLINK_EN is defined.
module disp_source_arbiter #(
    parameter int unsigned N_SRC       = 4,
    parameter int unsigned HOLD_TICKS  = 250,
    parameter int unsigned BLINK_TICKS = 125
) (
    input  logic                 clk_250Hz,
    input  logic                 rst_n,
    input  logic [N_SRC-1:0]     req,
    input  logic [32*N_SRC-1:0]  src_data,
    input  logic                 alert,
    output logic [N_SRC-1:0]     grant,
    output logic [31:0]          data_out,
    output logic                 busy
);

    localparam int unsigned IdxW  = $clog2(N_SRC);
    localparam int unsigned HoldW = $clog2(HOLD_TICKS);

    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(N_SRC - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_TICKS - 1);
    localparam logic [31:0]      Blank    = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        StIdle,
        StShow
    } state_e;

    state_e             state_q, state_d;
    logic [IdxW-1:0]    ptr_q, ptr_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [N_SRC-1:0]   grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        norm_d;

    logic [N_SRC-1:0]   search_mask;
    logic [IdxW-1:0]    cand_idx;
    logic [IdxW-1:0]    win_idx;
    logic               win_found;
    logic [31:0]        owner_data;
    logic [31:0]        win_data;

    // While showing, ptr_q is the owner; masking it out makes the winner always a competitor.
    always_comb begin
        search_mask = req;
        if (state_q == StShow) begin
            search_mask[ptr_q] = 1'b0;
        end
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand_idx  = ptr_q;
        for (int unsigned i = 1; i <= N_SRC; i++) begin
            cand_idx = IdxW'((32'(ptr_q) + i) % N_SRC);
            if (!win_found && search_mask[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    assign owner_data = src_data[32*ptr_q +: 32];
    assign win_data   = src_data[32*win_idx +: 32];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        norm_d  = Blank;

        unique case (state_q)
            StIdle: begin
                grant_d = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
                if (win_found) begin
                    state_d = StShow;
                    ptr_d   = win_idx;
                    grant_d = N_SRC'(1) << win_idx;
                    busy_d  = 1'b1;
                    norm_d  = win_data;
                end
            end

            StShow: begin
                if (!req[ptr_q] || (hold_q == HoldLast)) begin
                    hold_d = '0;
                    if (win_found) begin
                        ptr_d   = win_idx;
                        grant_d = N_SRC'(1) << win_idx;
                        busy_d  = 1'b1;
                        norm_d  = win_data;
                    end else if (req[ptr_q]) begin
                        // Dwell expired with no competitor: owner simply keeps the display.
                        norm_d = owner_data;
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                        busy_d  = 1'b0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                    norm_d = owner_data;
                end
            end

            default: begin
                state_d = StIdle;
                grant_d = '0;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

`ifdef DISP_BLINK_EN
    localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_TICKS - 1);

    logic              phase_on_q, phase_on_d;
    logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;

    always_comb begin
        phase_on_d  = phase_on_q;
        blink_cnt_d = blink_cnt_q;
        if (!alert) begin
            phase_on_d  = 1'b1;
            blink_cnt_d = '0;
        end else if (busy_q) begin
            if (blink_cnt_q == BlinkLast) begin
                blink_cnt_d = '0;
                phase_on_d  = ~phase_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
        // Blanking uses the next phase so the word and its phase are registered together.
        data_d = phase_on_d ? norm_d : Blank;
    end

    always_ff @(posedge clk_250Hz or negedge rst_n) begin
        if (!rst_n) begin
            phase_on_q  <= 1'b1;
            blink_cnt_q <= '0;
        end else begin
            phase_on_q  <= phase_on_d;
            blink_cnt_q <= blink_cnt_d;
        end
    end
`else
    logic unused_alert;
    assign unused_alert = alert;
    assign data_d       = norm_d;
`endif

    always_ff @(posedge clk_250Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= IdxLast;
            hold_q  <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            data_q  <= Blank;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
        end
    end

    assign grant    = grant_q;
    assign busy     = busy_q;
    assign data_out = data_q;

endmodule

// File: tb/tb_disp_source_arbiter.sv
// Directed bench for disp_source_arbiter with N_SRC=4, HOLD_TICKS=4, BLINK_TICKS=3.
module tb_disp_source_arbiter;

    localparam int unsigned N = 4;

    logic             clk_250Hz;
    logic             rst_n;
    logic [N-1:0]     req;
    logic [32*N-1:0]  src_data;
    logic             alert;
    logic [N-1:0]     grant;
    logic [31:0]      data_out;
    logic             busy;

    int unsigned n_checks;
    int unsigned n_errors;

    disp_source_arbiter #(
        .N_SRC       (N),
        .HOLD_TICKS  (4),
        .BLINK_TICKS (3)
    ) dut (
        .clk_250Hz (clk_250Hz),
        .rst_n     (rst_n),
        .req       (req),
        .src_data  (src_data),
        .alert     (alert),
        .grant     (grant),
        .data_out  (data_out),
        .busy      (busy)
    );

    initial begin
        clk_250Hz = 1'b0;
        forever #5 clk_250Hz = ~clk_250Hz;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_250Hz);
        #1;
    endtask

    // Called just after an edge, so the pulse sits between clock edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".grant"}, 32'(grant), 32'h0);
        check({tag, ".busy"},  32'(busy),  32'h0);
        check({tag, ".data"},  data_out,   32'hFFFF_FFFF);
    endtask

    logic [3:0]  rot_grant [12];
    logic [31:0] blink_exp [8];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        req      = '0;
        src_data = '0;
        alert    = 1'b0;
        src_data[32*0 +: 32] = 32'h1111_1111;
        src_data[32*1 +: 32] = 32'h2222_2222;
        src_data[32*3 +: 32] = 32'h3333_3333;

        #22;
        check_idle("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle("idle");
        end

        // Single source, held with no competitor past the dwell.
        src_data[32*2 +: 32] = 32'h1234_5678;
        req = 4'b0100;
        tick();
        check("single.grant", 32'(grant), 32'h4);
        check("single.busy",  32'(busy),  32'h1);
        check("single.data",  data_out,   32'h1234_5678);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("single.hold", 32'(grant), 32'h4);
        end
        src_data[32*2 +: 32] = 32'hAABB_CCDD;
        tick();
        check("single.live", data_out, 32'hAABB_CCDD);
        req = '0;
        tick();
        check_idle("single.drop");

        // Rotation with wrap 3 -> 0.
        pulse_reset();
        rot_grant = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h8, 4'h8, 4'h8, 4'h8,
                      4'h1, 4'h1, 4'h1, 4'h1};
        req = 4'b1001;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rot.grant", 32'(grant), 32'(rot_grant[i]));
            check("rot.data", data_out,
                  (rot_grant[i] == 4'h1) ? 32'h1111_1111 : 32'h3333_3333);
        end
        req = '0;
        tick();
        check_idle("rot.drop");

        // Early drop by the owner, then full drop.
        pulse_reset();
        req = 4'b0011;
        tick();
        check("early.first", 32'(grant), 32'h1);
        tick();
        req = 4'b0010;
        tick();
        check("early.regrant", 32'(grant), 32'h2);
        check("early.data",    data_out,   32'h2222_2222);
        req = 4'b0011;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("early.dwell", 32'(grant), 32'h2);
        end
        tick();
        check("early.rotate", 32'(grant), 32'h1);
        req = '0;
        tick();
        check_idle("early.idle");

        // Asynchronous reset while source 2 owns the display.
        pulse_reset();
        req = 4'b0100;
        tick();
        check("midrst.own", 32'(grant), 32'h4);
        rst_n = 1'b0;
        #2;
        check_idle("midrst");
        rst_n = 1'b1;
        req = 4'b0110;
        tick();
        check("midrst.first", 32'(grant), 32'h2);

        // Alert blink (ignored when the feature is not built).
        req = 4'b0010;
        src_data[32*1 +: 32] = 32'h0F0F_0F0F;
        tick();
        check("blink.pre", data_out, 32'h0F0F_0F0F);
`ifdef DISP_BLINK_EN
        blink_exp = '{32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F};
`else
        blink_exp = '{default: 32'h0F0F_0F0F};
`endif
        alert = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("blink.data",  data_out,   blink_exp[i]);
            check("blink.grant", 32'(grant), 32'h2);
        end
        tick();
`ifdef DISP_BLINK_EN
        check("blink.off2", data_out, 32'hFFFF_FFFF);
`else
        check("blink.off2", data_out, 32'h0F0F_0F0F);
`endif
        alert = 1'b0;
        tick();
        check("blink.restore", data_out, 32'h0F0F_0F0F);
        req = '0;
        tick();
        check_idle("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/disp_source_arbiter.md
# disp_source_arbiter

Shares the 4-digit seven-segment display driver between up to `N_SRC` requesting sources. It grants the display round-robin, holding each granted source for a minimum dwell time. It delivers the granted source's 32-bit segment pattern as a registered word to the display scan driver's `data` input. It also provides an optional alert blink that blanks the display periodically.

## Interface
Parameters:
- `N_SRC`, 4: number of requesting sources, 2..8.
- `HOLD_TICKS`, 250: dwell per grant in clock cycles (1 s at 250 Hz), ≥2.
- `BLINK_TICKS`, 125: half-period of the alert blink in cycles, ≥1.

Ports:
- `clk_250Hz`  in  1  system clock, the display scan clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  `N_SRC`  level request per source; bit i = source i wants the display.
- `src_data`  in  `32*N_SRC`  segment patterns; source i at bits [32*i+31:32*i], digit 3 in the MSB byte, active-low segments.
- `alert`  in  1  level; requests blinking of the shown content.
- `grant`  out  `N_SRC`  one-hot current owner, all-zero when idle.
- `data_out`  out  32  pattern to the display driver.
- `busy`  out  1  high when a source is granted.

## Operation
- Two states: `IDLE` and `SHOW`.
  - All output values below are registered.
  - `ptr` holds the index of the last granted source.
- Round-robin search: starting at `(ptr+1) mod N_SRC`, pick the first index with `req` set, wrapping N_SRC-1 → 0.
- `IDLE`:
  - `grant=0`, `busy=0`, `data_out=32'hFFFFFFFF` (all segments off).
  - If any `req` is set, grant the search winner, load `hold_cnt=0`, and go to `SHOW`.
- `SHOW` (owner k):
  - `data_out` follows `src_data[k]` every cycle with a 1-cycle register delay, so live updates from the owner pass through.
  - `hold_cnt` increments each cycle.
- Owner drops `req[k]`: on the next edge the block re-arbitrates immediately without waiting for the dwell.
  - If another request is pending, it grants the search winner and clears `hold_cnt`.
  - Otherwise it goes to `IDLE`.
- `hold_cnt == HOLD_TICKS-1` with `req[k]` still set:
  - If another source requests, it grants the search winner, which is never k.
  - If no other source requests, k keeps the grant and `hold_cnt` restarts at 0.
- `ptr` updates to the new owner on every grant.
- Requests from non-owners that rise and fall within one dwell window are never served.
- Simultaneous owner-drop and dwell expiry are handled as owner-drop.
- `grant` and `data_out` change on the same edge. `data_out` for a new owner is `src_data` of that owner as sampled at that edge.

## Timing
- Reset (asynchronous):
  - `state=IDLE`, `grant=0`, `busy=0`, `data_out=32'hFFFFFFFF`.
  - `ptr=N_SRC-1`, so the first search starts at source 0.
  - `hold_cnt=0`, blink phase=on, `blink_cnt=0`.
- Request to grant latency: 1 cycle from `IDLE`.
- Data latency: 1 cycle from `src_data` to `data_out`.
- Dwell: an owner with a continuous request and competitors present holds exactly `HOLD_TICKS` cycles.
- Reset mid-operation returns to the reset values immediately. After release, the first grant starts at source 0.

## Configuration
- `DISP_BLINK_EN` defined:
  - While `alert=1` and `busy=1`, `blink_cnt` counts to `BLINK_TICKS-1` and then toggles the phase.
  - During the off phase, `data_out=32'hFFFFFFFF`; during the on phase, `data_out` carries the normal data.
  - `alert=0` forces phase=on and `blink_cnt=0` on the next edge.
  - The first blank begins `BLINK_TICKS` cycles after `alert` rises.
  - Arbitration and `grant` are unaffected.
- `DISP_BLINK_EN` undefined: `alert` is ignored and the blink logic is not synthesized.

## Test plan
- Reset then idle: `rst_n` low then high, `req=0` → `grant=0`, `busy=0`, `data_out=FFFFFFFF` indefinitely.
- Single source: `req=4'b0100`, `src_data[2]=32'h12345678` → one cycle later `grant=4'b0100`, `data_out=12345678`. Grant held with no competitor beyond `HOLD_TICKS`. Change `src_data[2]` to `AABBCCDD` → visible one cycle later.
- Rotation and wrap with `HOLD_TICKS=4`, `req=4'b1001` → grant sequence 0001 ×4 cycles, 1000 ×4, 0001 ×4, confirming the 3→0 wrap.
- Early drop: owner 0 with `req=4'b0011`, drop `req[0]` at `hold_cnt=1` → next edge `grant=0010`, `hold_cnt=0`. Drop `req[1]` too → `IDLE`, `data_out=FFFFFFFF`.
- Blink (`DISP_BLINK_EN`, `BLINK_TICKS=3`): owner showing `0F0F0F0F`, raise `alert` → 3 cycles data, 3 cycles `FFFFFFFF`, repeating. `alert=0` → data restored on the next edge.
- Reset mid-operation: while source 2 is granted, pulse `rst_n` low between clock edges → outputs go to reset values immediately. With `req=4'b0110` after release, the first grant is `0010`.
